// File: rtl/countdown_arbiter.sv
// Round-robin arbiter that shares one programmable countdown timer among N_REQ requesters.
// The winner's length is loaded, counted down to zero, and a one-cycle done pulse goes back to the owner.
module countdown_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [CNT_W-1:0]       count,
    output logic [N_REQ-1:0]       done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [IDX_W-1:0] owner_r;
    logic [IDX_W-1:0] owner_nx_s;
    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] last_nx_s;
    logic [IDX_W-1:0] pick_s;
    logic             pick_vld_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic [N_REQ-1:0] grant_r;
    logic [N_REQ-1:0] grant_nx_s;
    logic [N_REQ-1:0] done_r;
    logic [N_REQ-1:0] done_nx_s;
    logic             busy_r;
    logic             busy_nx_s;

    // Index base+off wrapped modulo N_REQ (off is at most N_REQ, so one subtraction suffices).
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search starting just after the last owner.
    always_comb begin
        pick_s     = last_r;
        pick_vld_s = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!pick_vld_s && req[rr_next(last_r, i)]) begin
                pick_s     = rr_next(last_r, i);
                pick_vld_s = 1'b1;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Next-state and datapath: req/len are only looked at while IDLE.
    always_comb begin
        next_state_s = state_r;
        owner_nx_s   = owner_r;
        last_nx_s    = last_r;
        count_nx_s   = count_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    next_state_s = RUN;
                    owner_nx_s   = pick_s;
                    last_nx_s    = pick_s;
                    count_nx_s   = len[int'(pick_s)*CNT_W +: CNT_W];
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == {CNT_W{1'b0}}) begin
                    next_state_s = FIRE;
                end else begin
                    count_nx_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            FIRE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so grant/busy/done can be registered with it.
    always_comb begin
        grant_nx_s = {N_REQ{1'b0}};
        done_nx_s  = {N_REQ{1'b0}};
        busy_nx_s  = 1'b0;
        case (next_state_s)
            IDLE: begin
                busy_nx_s = 1'b0;
            end
            RUN: begin
                grant_nx_s[owner_nx_s] = 1'b1;
                busy_nx_s              = 1'b1;
            end
            FIRE: begin
                grant_nx_s[owner_nx_s] = 1'b1;
                done_nx_s[owner_nx_s]  = 1'b1;
                busy_nx_s              = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; last resets to N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= {IDX_W{1'b0}};
            last_r  <= IDX_W'(N_REQ - 1);
            count_r <= {CNT_W{1'b0}};
            grant_r <= {N_REQ{1'b0}};
            done_r  <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            owner_r <= owner_nx_s;
            last_r  <= last_nx_s;
            count_r <= count_nx_s;
            grant_r <= grant_nx_s;
            done_r  <= done_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    assign grant = grant_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign count = count_r;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed, table-driven bench for countdown_arbiter (N_REQ=4, CNT_W=8) with hand-computed per-cycle expectations.
module tb_countdown_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam logic [31:0] L1 = 32'h01010101;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] len;
        logic [3:0]  g;
        logic        b;
        logic [7:0]  c;
        logic [3:0]  d;
    } vec_t;

    vec_t vecs[$];

    countdown_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] q, input logic [31:0] l,
                       input logic [3:0] g, input logic b, input logic [7:0] c, input logic [3:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.len = l; v.g = g; v.b = b; v.c = c; v.d = d;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] l);
        rst = r;
        req = q;
        len = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic eb,
                         input logic [7:0] ec, input logic [3:0] ed);
        tests++;
        if ({grant, busy, count, done} !== {eg, eb, ec, ed}) begin
            fails++;
            $display("FAIL %s: got grant=%b busy=%b count=%0d done=%b, expected grant=%b busy=%b count=%0d done=%b",
                     tag, grant, busy, count, done, eg, eb, ec, ed);
        end
        tests++;
        if ((done & ~grant) !== 4'b0000) begin
            fails++;
            $display("FAIL %s_done_without_grant: got done=%b grant=%b, expected done subset of grant",
                     tag, done, grant);
        end
    endtask

    initial begin
        // Reset, then idle for 10 cycles.
        add(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);
        add(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);
        for (int i = 0; i < 10; i++) add(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);

        // Single request: requester 2, length 3.
        add(1'b0, 4'b0100, 32'h00030000, 4'b0100, 1'b1, 8'd3, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0100, 1'b1, 8'd2, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0100, 1'b1, 8'd1, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0100, 1'b1, 8'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0100, 1'b1, 8'd0, 4'b0100);
        add(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);

        // Zero length on requester 1: two busy cycles.
        add(1'b0, 4'b0010, 32'h0, 4'b0010, 1'b1, 8'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0010, 1'b1, 8'd0, 4'b0010);
        add(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);

        // Last owner is 1: with req 0 and 1 pending, search wraps 2,3,0 and picks 0.
        add(1'b0, 4'b0011, 32'h0, 4'b0001, 1'b1, 8'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0001, 1'b1, 8'd0, 4'b0001);
        add(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);

        // Round-robin from reset with all requests held, all lengths 1.
        add(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'(1 << (k % 4));
            add(1'b0, 4'b1111, L1, oh, 1'b1, 8'd1, 4'b0000);
            add(1'b0, 4'b1111, L1, oh, 1'b1, 8'd0, 4'b0000);
            add(1'b0, 4'b1111, L1, oh, 1'b1, 8'd0, oh);
            add(1'b0, 4'b1111, L1, 4'b0000, 1'b0, 8'd0, 4'b0000);
        end

        // Mid-operation len/req changes on owner 1 are ignored.
        add(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);
        add(1'b0, 4'b0010, 32'h00000500, 4'b0010, 1'b1, 8'd5, 4'b0000);
        for (int c = 4; c >= 0; c--) add(1'b0, 4'b0000, 32'h0, 4'b0010, 1'b1, 8'(c), 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0010, 1'b1, 8'd0, 4'b0010);
        add(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);

        // Reset during RUN aborts the owner: no done pulse afterwards.
        add(1'b0, 4'b0001, 32'h00000004, 4'b0001, 1'b1, 8'd4, 4'b0000);
        add(1'b0, 4'b0000, 32'h0, 4'b0001, 1'b1, 8'd3, 4'b0000);
        add(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'd0, 4'b0000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].len);
            check($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].c, vecs[i].d);
        end

        // Maximum length 255 on requester 0: full countdown without wrap.
        drive(1'b0, 4'b0001, 32'h000000FF);
        check("max_load", 4'b0001, 1'b1, 8'd255, 4'b0000);
        for (int k = 254; k >= 0; k--) begin
            drive(1'b0, 4'b0000, 32'h0);
            check($sformatf("max_cnt%0d", k), 4'b0001, 1'b1, 8'(k), 4'b0000);
        end
        drive(1'b0, 4'b0000, 32'h0);
        check("max_fire", 4'b0001, 1'b1, 8'd0, 4'b0001);
        drive(1'b0, 4'b0000, 32'h0);
        check("max_idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_arbiter.md
Name: countdown_arbiter

Overview:
- Shares one programmable countdown timer among N_REQ requesters. Arbitration is round-robin.
- The winning requester's length is loaded and counted down to zero. A one-cycle done pulse then goes back to that requester.
- Used wherever several blocks need a fixed-delay trigger but the design provides only one timer resource.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- CNT_W, 8: countdown length width in bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request, one bit per requester.
- len  input  N_REQ*CNT_W  packed lengths; requester i uses len[i*CNT_W +: CNT_W].
- grant  output  N_REQ  one-hot, registered; marks the current owner of the timer.
- busy  output  1  high whenever the FSM is not in IDLE.
- count  output  CNT_W  current countdown value.
- done  output  N_REQ  one-hot, one-cycle pulse to the owner when its countdown completes.

Behaviour:
- All state is registered. Outputs are Moore-style, decoded from state plus the registered owner index. There is no combinational path from req/len to any output.
- Reset (rst high at a posedge) forces the following, regardless of the current state:
  - state=IDLE
  - grant=0, done=0, busy=0, count=0
  - RR pointer last=N_REQ-1, so requester 0 has highest priority first.
- States:
  - IDLE: grant=0, busy=0, done=0. At a posedge with any req bit set:
    - Select the first set bit searching last+1, last+2, ... modulo N_REQ.
    - Latch owner index, latch count<=len[owner], set last<=owner.
    - Go to RUN.
    - With no req set, stay in IDLE; count holds its value.
  - RUN: grant[owner]=1, busy=1, done=0. At each posedge:
    - If count==0, go to FIRE.
    - Otherwise count<=count-1.
  - FIRE: grant[owner]=1, busy=1, done[owner]=1 for exactly this one cycle. At the next posedge go to IDLE.
- Latency:
  - Arbitration posedge is E0; RUN holds count=L after E0.
  - FIRE (done high) is the cycle following posedge E0+L+1.
  - IDLE is re-entered at E0+L+2.
  - The earliest next arbitration is at posedge E0+L+3.
  - L=0 is legal: done is high the cycle after E0+1.
  - L=2^CNT_W-1 is legal. There is no wrap, because decrement never occurs at 0.
- req/len are sampled only in IDLE.
  - Changes to req or len during RUN or FIRE are ignored.
  - The owner's countdown always completes, even if its req drops.
- Requester responsibility: a requester must drop req in the cycle it sees done, or it re-enters arbitration. RR ordering still gives every other pending requester priority over it.
- Fairness: with all N_REQ requests held high continuously, grants rotate 0,1,2,...,N_REQ-1,0,...
- Reset mid-operation: if rst arrives during RUN, done is never pulsed for the aborted owner.
- grant and done are never both set for different indices. done is set only while grant has the same bit set.

Test Plan:
- Reset then idle: assert rst 2 cycles, req=0 → grant=0, busy=0, done=0, count=0 held for 10 cycles.
- Single request: N_REQ=4, req=4'b0100, len[2]=3, arbitration at E0 → grant=4'b0100 from E0; done=4'b0100 for one cycle after E0+4; busy falls after E0+5.
- Zero length: req[1]=1, len[1]=0 → done[1] pulses in the cycle after E0+1; total busy = 2 cycles.
- Round-robin: req=4'b1111 held, all len=1 → owners granted in order 0,1,2,3,0; exactly one done pulse per grant; no owner granted twice in a row.
- Mid-operation changes: during RUN for owner 1 (len=5), change len[1] to 0 and drop req[1] → countdown still completes 5..0 and done[1] still fires. Separately, assert rst during RUN → next cycle all outputs 0 and no done pulse.
- Max length: CNT_W=8, len[0]=255 → count decrements 255→0 without wrap; done[0] after E0+256.
